// File: rtl/vector_loader_pkg.sv
// Shared fetch-redirect definitions: source selectors,
// vector_loader state encoding and vector table stride.
package vector_loader_pkg;

  typedef enum logic [1:0] {
    RSTSRC   = 2'b00,
    EXPT1SRC = 2'b01,
    EXPT2SRC = 2'b10,
    INTSRC   = 2'b11
  } fetch_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_HI = 2'b01,
    RD_LO = 2'b10,
    DONE  = 2'b11
  } vl_state_e;

  localparam int VEC_STRIDE = 2;

endpackage

// File: rtl/vector_loader_if.sv
// Half-word instruction-memory read port used by
// vector_loader (master) and the memory (slave).
interface vector_loader_if #(
  parameter int ADDR_W = 32
);

  logic              memRead;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memData;
  logic              memReady;

  modport master (
    output memRead,
    output memAddr,
    input  memData,
    input  memReady
  );

  modport slave (
    input  memRead,
    input  memAddr,
    output memData,
    output memReady
  );

endinterface

// File: rtl/vector_loader.sv
// Reads a 32-bit big-endian handler vector as two half-words and
// strobes it into the PC. VEC_ALIGN_CHECK_EN masks/flags bits [1:0].
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [1:0]        fetchSrc,
  vector_loader_if.master   mem,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcValue,
  output logic              busy,
  output logic              vecErr
);

  vl_state_e         state_q;
  vl_state_e         state_d;
  fetch_src_e        src_q;
  logic [15:0]       hi_q;
  logic [ADDR_W-1:0] entry;
  logic [31:0]       raw_vec;
  logic [31:0]       pc_next;
  logic              err_next;
  logic              lo_done;

  assign entry = VEC_BASE
               + ADDR_W'(src_q) * ADDR_W'(VEC_STRIDE);

  assign raw_vec = {hi_q, mem.memData};
  assign lo_done = (state_q == RD_LO) && mem.memReady && !fetch;

`ifdef VEC_ALIGN_CHECK_EN
  logic err_q;

  assign pc_next  = {raw_vec[31:2], 2'b00};
  assign err_next = |raw_vec[1:0];
  assign vecErr   = pcLoad & err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (lo_done) begin
      err_q <= err_next;
    end
  end
`else
  assign pc_next  = raw_vec;
  assign err_next = 1'b0;
  assign vecErr   = err_next;
`endif

  always_comb begin
    state_d     = state_q;
    mem.memRead = 1'b0;
    mem.memAddr = '0;
    pcLoad      = 1'b0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (fetch) state_d = RD_HI;
      end
      RD_HI: begin
        mem.memRead = 1'b1;
        mem.memAddr = entry;
        if (mem.memReady) state_d = RD_LO;
      end
      RD_LO: begin
        mem.memRead = 1'b1;
        mem.memAddr = entry + ADDR_W'(1);
        if (mem.memReady) state_d = DONE;
      end
      DONE: begin
        pcLoad  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new request always wins, even over the load strobe.
    if (fetch) begin
      state_d = RD_HI;
      pcLoad  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= RSTSRC;
      hi_q    <= '0;
      pcValue <= '0;
    end else begin
      state_q <= state_d;
      if (fetch) begin
        src_q <= fetch_src_e'(fetchSrc);
        hi_q  <= '0;
      end else if (state_q == RD_HI && mem.memReady) begin
        hi_q <= mem.memData;
      end else if (lo_done) begin
        pcValue <= ADDR_W'(pc_next);
      end
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader: directed plan steps plus
// randomized wait states, sources and preemption against a timeline model.
module tb_vector_loader;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic [1:0]  fetchSrc;
  logic        rdy;
  logic        pcLoad;
  logic [31:0] pcValue;
  logic        busy;
  logic        vecErr;

  logic        wfetch;
  logic [1:0]  wsrc;
  logic        wpcLoad;
  logic [31:0] wpcValue;
  logic        wbusy;
  logic        wvecErr;

  logic [15:0] mem [256];

  int checks;
  int errors;

  vector_loader_if #(.ADDR_W(32)) bus ();
  vector_loader_if #(.ADDR_W(32)) wbus ();

  assign bus.memReady  = rdy;
  assign bus.memData   = mem[bus.memAddr[7:0]];
  assign wbus.memReady = 1'b1;
  assign wbus.memData  = mem[wbus.memAddr[7:0]];

  vector_loader #(.ADDR_W(32), .VEC_BASE(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fetch),
    .fetchSrc (fetchSrc),
    .mem      (bus),
    .pcLoad   (pcLoad),
    .pcValue  (pcValue),
    .busy     (busy),
    .vecErr   (vecErr)
  );

  vector_loader #(.ADDR_W(32), .VEC_BASE(32'hFFFF_FFFE)) dutw (
    .clk      (clk),
    .rst      (rst),
    .fetch    (wfetch),
    .fetchSrc (wsrc),
    .mem      (wbus),
    .pcLoad   (wpcLoad),
    .pcValue  (wpcValue),
    .busy     (wbusy),
    .vecErr   (wvecErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pc(input logic [31:0] raw);
`ifdef VEC_ALIGN_CHECK_EN
    return raw & 32'hFFFF_FFFC;
`else
    return raw;
`endif
  endfunction

  function automatic logic exp_err(input logic [31:0] raw);
`ifdef VEC_ALIGN_CHECK_EN
    return raw[1] | raw[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".memRead"}, 32'(bus.memRead), 32'd0);
    check({tag, ".memAddr"}, bus.memAddr, 32'd0);
    check({tag, ".pcLoad"}, 32'(pcLoad), 32'd0);
    check({tag, ".pcValue"}, pcValue, 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".vecErr"}, 32'(vecErr), 32'd0);
  endtask

  // Cycle 0: request sampled at the coming edge while idle.
  task automatic issue(input int src);
    fetch    = 1'b1;
    fetchSrc = 2'(src);
    rdy      = 1'b0;
    #1;
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.pcLoad", 32'(pcLoad), 32'd0);
    tick();
    fetch = 1'b0;
  endtask

  // Cycles 1..L of a sequence with whi/wlo memory wait cycles.
  task automatic follow(input int src, input int whi, input int wlo);
    int          len;
    logic [31:0] a;
    logic [31:0] raw;
    len = 3 + whi + wlo;
    a   = 32'(src) * 2;
    raw = {mem[a[7:0]], mem[a[7:0] + 8'd1]};
    for (int k = 1; k <= len; k++) begin
      rdy = (k == 1 + whi) || (k == 2 + whi + wlo);
      #1;
      check("memRead", 32'(bus.memRead), 32'(k < len));
      if (k < len)
        check("memAddr", bus.memAddr, (k <= 1 + whi) ? a : a + 1);
      check("busy", 32'(busy), 32'd1);
      check("pcLoad", 32'(pcLoad), 32'(k == len));
      if (k == len) begin
        check("pcValue", pcValue, exp_pc(raw));
        check("vecErr", 32'(vecErr), 32'(exp_err(raw)));
      end
      tick();
    end
    rdy = 1'b0;
  endtask

  // Start src a, interrupt with src b at cycle at (1..3), then finish b.
  task automatic preempt(input int a, input int at, input int b,
                         input int whi, input int wlo);
    issue(a);
    for (int k = 1; k <= at; k++) begin
      rdy = 1'b1;
      if (k == at) begin
        fetch    = 1'b1;
        fetchSrc = 2'(b);
      end
      #1;
      check("pre.busy", 32'(busy), 32'd1);
      check("pre.pcLoad", 32'(pcLoad), 32'd0);
      check("pre.vecErr", 32'(vecErr), 32'd0);
      tick();
    end
    fetch = 1'b0;
    follow(b, whi, wlo);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    fetch    = 1'b0;
    fetchSrc = 2'b00;
    rdy      = 1'b0;
    wfetch   = 1'b0;
    wsrc     = 2'b00;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    tick();
    tick();
    check_reset_outs("rst");
    rst = 1'b1;
    tick();

    mem[0] = 16'h0000;
    mem[1] = 16'h0100;
    issue(0);
    follow(0, 0, 0);

    mem[6] = 16'h1234;
    mem[7] = 16'hABCC;
    issue(3);
    follow(3, 2, 2);

    mem[2] = 16'h5678;
    mem[3] = 16'h9AB0;
    mem[4] = 16'hDEAD;
    mem[5] = 16'hBEEF;
    preempt(2, 2, 1, 0, 0);

    mem[4] = 16'h0040;
    mem[5] = 16'h0003;
    issue(2);
    follow(2, 0, 0);

    issue(1);
    rdy = 1'b0;
    #1;
    check("arst.memAddr.pre", bus.memAddr, 32'd2);
    rst = 1'b0;
    #1;
    check_reset_outs("arst");
    tick();
    check("arst.pcLoad", 32'(pcLoad), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    issue(0);
    follow(0, 1, 0);

    for (int n = 0; n < 24; n++) begin
      int s;
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      s = $urandom_range(0, 3);
      if (n % 3 == 2)
        preempt($urandom_range(0, 3), $urandom_range(1, 3), s,
                $urandom_range(0, 3), $urandom_range(0, 3));
      else begin
        issue(s);
        follow(s, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    mem[0] = 16'hC0DE;
    mem[1] = 16'h0042;
    wfetch = 1'b1;
    wsrc   = 2'b01;
    tick();
    wfetch = 1'b0;
    #1;
    check("wrap.addr0", wbus.memAddr, 32'h0000_0000);
    tick();
    #1;
    check("wrap.addr1", wbus.memAddr, 32'h0000_0001);
    tick();
    #1;
    check("wrap.pcLoad", 32'(wpcLoad), 32'd1);
    check("wrap.pcValue", wpcValue, exp_pc(32'hC0DE_0042));
    tick();
    #1;
    check("wrap.busy", 32'(wbusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_loader.md
# vector_loader

Responder side of the fetch-redirect interface. On a `fetch` request with a `fetchSrc` selector, it reads the 32-bit handler address for that source from the vector table in 16-bit instruction memory, as two half-word reads. It then pulses `pcLoad` with the assembled address into the PC register. It sits between fetch control and the instruction-memory port, and asserts `busy` to stall fetch while the vector read is in flight.

## Interface
- `VEC_BASE`, default 0: half-word address of vector table entry 0.
- `ADDR_W`, default 32: width of memory address and PC.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  redirect request, sampled every cycle.
- `fetchSrc`  in  2  vector selector: 00 reset, 01 exception 1, 10 exception 2, 11 interrupt.
- `memRead`  out  1  instruction-memory read request.
- `memAddr`  out  ADDR_W  half-word address of the current read.
- `memData`  in  16  read data, valid when `memReady`=1.
- `memReady`  in  1  read completes this cycle.
- `pcLoad`  out  1  one-cycle strobe: load `pcValue` into PC.
- `pcValue`  out  ADDR_W  assembled vector, held until next load.
- `busy`  out  1  high in every non-IDLE state.
- `vecErr`  out  1  misaligned-vector flag (see Configuration).

## Operation
- States: IDLE, RD_HI, RD_LO, DONE.
- IDLE: outputs inactive. On `fetch`=1, latch `fetchSrc` and go to RD_HI.
- RD_HI: `memRead`=1, `memAddr`=VEC_BASE+2·src. On `memReady`, capture `memData` into vector[31:16] and go to RD_LO. Otherwise stay.
- RD_LO: `memRead`=1, `memAddr`=VEC_BASE+2·src+1. On `memReady`, capture vector[15:0] and go to DONE. Otherwise stay.
- DONE: `pcLoad`=1, `pcValue`=assembled vector. Next state IDLE.
- Half-word order is big-endian: the lower address holds bits 31:16.
- Address arithmetic: 2·src is zero-extended to ADDR_W. Sum wraps modulo 2^ADDR_W.
- Preemption: `fetch`=1 in any non-IDLE state aborts the sequence.
  - Latch the new `fetchSrc` and go to RD_HI next cycle.
  - Discard partial data.
  - Suppress `pcLoad` in that cycle, including in DONE.
- `memReady` is ignored while `memRead`=0.
- Reset values:
  - State IDLE, latched src 00, vector 0.
  - `memRead`=0, `memAddr`=0, `pcLoad`=0, `pcValue`=0, `busy`=0, `vecErr`=0.
- Reset mid-sequence: return to IDLE immediately. No `pcLoad` issues.

## Timing
- State and captured data are registered. `memRead`, `memAddr`, `pcLoad` and `busy` are decoded combinationally from registered state.
- `pcValue` is registered and stable from the DONE cycle until the next DONE.
- Minimum latency with `memReady` tied 1: `fetch` sampled at edge 0, RD_HI cycle 1, RD_LO cycle 2, `pcLoad` cycle 3.
- Each memory wait cycle adds one cycle of latency.
- `busy` rises the cycle after `fetch` is sampled and falls the cycle after DONE.
- Back-to-back: `fetch` in the cycle after DONE (state IDLE) starts a new sequence without a gap.

## Configuration
- `VEC_ALIGN_CHECK_EN` defined:
  - In DONE, `pcValue[1:0]` is forced to 00.
  - `vecErr` pulses together with `pcLoad` if the raw vector had bit 1 or bit 0 set.
- Not defined:
  - `pcValue` is the raw 32-bit vector.
  - `vecErr` is tied 0.
  - The port list is identical in both builds.

## Structure
- The shared fetch package holds:
  - The fetchSrc encodings (RSTSRC=00, EXPT1SRC=01, EXPT2SRC=10, INTSRC=11). Fetch control uses the same constants.
  - The vector_loader state encoding.
  - The vector stride constant (2 half-words per entry).
- Single module, no sub-module. The half-word assembly is a pair of 16-bit registers and does not warrant one.

## Test plan
- Reset vector: VEC_BASE=0. Memory holds 0x0000 at addr 0 and 0x0100 at addr 1. `memReady`=1. Pulse `fetch` with src 00.
  - Expect reads of addr 0 then 1, and `pcLoad` 3 cycles after the request with `pcValue`=0x00000100.
- Interrupt vector with wait states: src 11. Memory holds 0x1234 at addr 6 and 0xABCC at addr 7. `memReady` low for 2 cycles on each read.
  - Expect `pcLoad` at cycle 7 with `pcValue`=0x1234ABCC, and `busy` high for cycles 1–7.
- Preemption: src 10 started. `fetch` with src 01 arrives during RD_LO.
  - Expect no `pcLoad` for src 10.
  - Expect a restart at addr 2, and a final `pcValue` equal to the contents of addr 2/3.
- Async reset mid-sequence: drop `rst` during RD_HI.
  - Expect all outputs to return to their reset values immediately and no `pcLoad`.
  - After release, expect the block to accept `fetch` normally.
- Alignment (macro on): vector 0x00400003.
  - Expect `pcValue`=0x00400000 and `vecErr`=1 in the DONE cycle.
  - Macro off: expect `pcValue`=0x00400003 and `vecErr`=0.
- Address wrap: VEC_BASE=0xFFFFFFFE, src 01. Expect `memAddr` 0x00000000 then 0x00000001.
